counter_seq_ctrl: RTL
=====================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, default 4, counter width in bits.
REQ-002 Parameter: WRAP_W, default 8, width of the wrap counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller accepts a command; a command is accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-007 cmd_op  input  2  operation: 00 START, 01 STOP, 10 PAUSE, 11 RESUME.
REQ-008 cmd_limit  input  CNT_W  terminal count; sampled only on an accepted START.
REQ-009 cmd_reload  input  1  auto-reload mode; sampled only on an accepted START.
REQ-010 count  output  CNT_W  current counter value.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 paused  output  1  high in PAUSE.
REQ-013 done  output  1  one-cycle pulse at terminal count.
REQ-014 wrap_cnt  output  WRAP_W  number of reloads since the last START; saturates at all-ones.

Function
REQ-015 FSM states: IDLE, RUN, PAUSE, DONE. cmd_ready is 1 in every state except DONE.
REQ-016 IDLE, START accepted at edge k: latch limit L and reload mode, count=0, wrap_cnt=0, state=RUN, all at edge k.
REQ-017 IDLE, STOP/PAUSE/RESUME: accept and ignore; no state or output change.
REQ-018 RUN: count increments by 1 per cycle; count reaches L at edge k+L.
REQ-019 RUN, count==L, reload=0: next edge state=DONE, done=1 for that one cycle, count holds at L.
REQ-020 DONE lasts exactly one cycle, then IDLE; count keeps holding L in IDLE.
REQ-021 RUN, count==L, reload=1: next edge count=0, done=1 for that one cycle, wrap_cnt+1 (saturating), state stays RUN.
REQ-022 L=0: terminal condition holds in the first RUN cycle.
- reload=0: DONE at edge k+1.
- reload=1: done pulses every cycle and count stays 0.
REQ-023 RUN, PAUSE accepted: state=PAUSE at that edge; no increment at that edge; count, terminal detection and done are frozen while paused.
REQ-024 PAUSE, RESUME accepted: state=RUN at that edge, count unchanged; incrementing resumes at the following edge.
REQ-025 RUN or PAUSE, STOP accepted: state=IDLE, count holds, no done pulse.
REQ-026 RUN or PAUSE, START accepted: restart per REQ-016 (new L, count=0, wrap_cnt=0).
REQ-027 PAUSE in PAUSE or RESUME in RUN: accept and ignore.
REQ-028 Simultaneous command and terminal count: an accepted command takes precedence; no done pulse and no reload in that cycle.
REQ-029 The count arithmetic never exceeds L, because terminal detection precedes increment; count never wraps past 2^CNT_W-1 except via reload.

Reset
REQ-030 With rst high at an edge: state=IDLE, count=0, done=0, busy=0, paused=0, wrap_cnt=0, latched L=0, reload=0.
REQ-031 Commands presented while rst is high are not accepted; cmd_ready=1 in the first cycle after rst deasserts.
REQ-032 rst asserted mid-RUN or mid-PAUSE aborts without a done pulse.

Structure
REQ-033 Shared package counter_seq_pkg holds the state enum and the cmd_op encodings (OP_START, OP_STOP, OP_PAUSE, OP_RESUME).
REQ-034 One sub-module, cnt_core (ports: clk, rst, clr, en, count; parameter CNT_W), holds the counter register; counter_seq_ctrl drives clr and en from its FSM.
REQ-035 All outputs are registered, except cmd_ready, which is decoded from the state register.

Verification
REQ-036 Run to done: rst 2 cycles, START L=5 reload=0 -> count 0,1,2,3,4,5; done=1 exactly one cycle after count=5; then IDLE with count=5 and busy=0.
REQ-037 Auto-reload: START L=3 reload=1, run 12 cycles -> count 0..3 repeating, done pulses 3 times, wrap_cnt=3.
REQ-038 Pause/resume: START L=9, PAUSE at count=4, hold 5 cycles, RESUME -> count stays 4 while paused=1; then 5..9 and done; 5 extra cycles to done.
REQ-039 Collision: START L=2 reload=0, STOP at the edge where count==2 -> IDLE, count=2, no done pulse.
REQ-040 Reset mid-run: START L=15, rst at count=7 -> count=0, busy=0, no done; a new START L=0 -> done at edge k+1.
REQ-041 Handshake: cmd_valid held high during the DONE cycle -> cmd_ready=0 and the command is accepted only in the following cycle.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the command-driven counter sequencer:
// FSM state encoding and the cmd_op command codes.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

endpackage

// File: rtl/counter_seq_ctrl_cnt_core.sv
// Counter register with synchronous clear (priority) and count enable;
// sequencing decisions are made entirely by the controlling FSM.
module cnt_core #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven counter sequencer: START/STOP/PAUSE/RESUME control of a
// counter running to a latched terminal count, with optional auto-reload.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_limit,
    input  logic              cmd_reload,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_limit;
    logic                r_reload;
    logic                r_busy;
    logic                r_paused;
    logic                r_done;
    logic [WRAP_W-1:0]   r_wrap;

    logic [CNT_W-1:0]    w_count;
    logic                w_acc;
    logic                w_start;
    logic                w_run;
    logic                w_term;
    logic                w_clr;
    logic                w_en;

    assign cmd_ready = (r_state != ST_DONE);
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_start   = w_acc && (cmd_op == OP_START);
    assign w_run     = (r_state == ST_RUN);
    assign w_term    = (w_count == r_limit);

    // Terminal detection gates the increment, so count never passes the limit.
    // Any accepted command other than an (ignored) RESUME in RUN overrides counting.
    assign w_clr = w_start || (w_run && w_term && r_reload && !w_acc);
    assign w_en  = w_run && !w_term && !(w_acc && (cmd_op != OP_RESUME));

    cnt_core #(
        .CNT_W (CNT_W)
    ) u_cnt_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_limit  <= '0;
            r_reload <= 1'b0;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state  <= ST_RUN;
                r_limit  <= cmd_limit;
                r_reload <= cmd_reload;
                r_busy   <= 1'b1;
                r_paused <= 1'b0;
                r_wrap   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_RUN: begin
                        if (w_acc) begin
                            if (cmd_op == OP_STOP) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else if (cmd_op == OP_PAUSE) begin
                                r_state  <= ST_PAUSE;
                                r_paused <= 1'b1;
                            end
                        end else if (w_term) begin
                            r_done <= 1'b1;
                            if (r_reload) begin
                                if (r_wrap != '1) begin
                                    r_wrap <= r_wrap + WRAP_W'(1);
                                end
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (w_acc) begin
                            if (cmd_op == OP_STOP) begin
                                r_state  <= ST_IDLE;
                                r_busy   <= 1'b0;
                                r_paused <= 1'b0;
                            end else if (cmd_op == OP_RESUME) begin
                                r_state  <= ST_RUN;
                                r_paused <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign count    = w_count;
    assign busy     = r_busy;
    assign paused   = r_paused;
    assign done     = r_done;
    assign wrap_cnt = r_wrap;

endmodule
